// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, second-operand generation, ALU,
// branch target, and the NZCV status register.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset of SR
//   EXE_CMD, S         ALU operation and flag-update request
//   MEM_R_EN, MEM_W_EN load/store markers (select 12-bit offset Val2)
//   B_in, PC           branch marker and PC+4 of the instruction
//   Val_1, Val_Rm      Rn and Rm/Rd values from ID/EXE
//   imm, shift_operand immediate bit and instruction[11:0]
//   Signed_imm_24      branch offset (words)
//   C_in               carry latched in ID/EXE
//   sel_src1, sel_src2 forwarding selects for Op1 and Rm
//   MEM_ALU_result     ALU result currently in EXE/MEM
//   WB_value           value currently being written back
//   Freeze             pipeline stall; SR holds while high
//   ALU_result         combinational ALU result
//   Store_value        forwarded Rm, store data
//   Branch_Address     combinational branch target
//   Branch_Taken       equals B_in
//   SR                 registered flags {N,Z,C,V}
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  EXE_CMD,
    input  logic        S,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic        B_in,
    input  logic [31:0] PC,
    input  logic [31:0] Val_1,
    input  logic [31:0] Val_Rm,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [23:0] Signed_imm_24,
    input  logic        C_in,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] MEM_ALU_result,
    input  logic [31:0] WB_value,
    input  logic        Freeze,
    output logic [31:0] ALU_result,
    output logic [31:0] Store_value,
    output logic [31:0] Branch_Address,
    output logic        Branch_Taken,
    output logic [3:0]  SR
);

    logic [31:0] op1;
    logic [31:0] rm_fwd;
    logic [31:0] val2;
    logic [63:0] rot_pair;
    logic [63:0] rm_pair;
    logic [4:0]  imm_rot;
    logic [4:0]  sh_amt;
    logic [32:0] sum;
    logic [31:0] add_b;
    logic        add_cin;
    logic        is_arith;
    logic        cmd_valid;
    logic        n_f, z_f, c_f, v_f;

    // Forwarding muxes; select 11 falls back to the ID/EXE value.
    always_comb begin
        unique case (sel_src1)
            2'b01:   op1 = MEM_ALU_result;
            2'b10:   op1 = WB_value;
            default: op1 = Val_1;
        endcase
        unique case (sel_src2)
            2'b01:   rm_fwd = MEM_ALU_result;
            2'b10:   rm_fwd = WB_value;
            default: rm_fwd = Val_Rm;
        endcase
    end

    assign Store_value = rm_fwd;

    // Rotations are taken from the low half of a doubled word, so an
    // amount of zero naturally leaves the value untouched.
    assign imm_rot  = {shift_operand[11:8], 1'b0};
    assign rot_pair = {24'd0, shift_operand[7:0], 24'd0, shift_operand[7:0]} >> imm_rot;
    assign sh_amt   = shift_operand[11:7];
    assign rm_pair  = {rm_fwd, rm_fwd} >> sh_amt;

    always_comb begin
        val2 = rm_fwd;
        if (imm) begin
            val2 = rot_pair[31:0];
        end else if (MEM_R_EN || MEM_W_EN) begin
            val2 = {20'd0, shift_operand};
        end else begin
            unique case (shift_operand[6:5])
                2'b00: val2 = rm_fwd << sh_amt;
                2'b01: val2 = rm_fwd >> sh_amt;
                2'b10: val2 = $unsigned($signed(rm_fwd) >>> sh_amt);
                2'b11: val2 = rm_pair[31:0];
            endcase
        end
    end

    // One 33-bit adder serves all four arithmetic ops; subtraction is
    // Op1 + ~Val2 + carry, so bit 32 is directly NOT borrow.
    always_comb begin
        add_b   = val2;
        add_cin = 1'b0;
        unique case (EXE_CMD)
            4'b0011: add_cin = C_in;
            4'b0100: begin
                add_b   = ~val2;
                add_cin = 1'b1;
            end
            4'b0101: begin
                add_b   = ~val2;
                add_cin = C_in;
            end
            default: ;
        endcase
    end

    assign sum = {1'b0, op1} + {1'b0, add_b} + {32'd0, add_cin};

    always_comb begin
        ALU_result = 32'd0;
        is_arith   = 1'b0;
        cmd_valid  = 1'b1;
        unique case (EXE_CMD)
            4'b0001: ALU_result = val2;
            4'b1001: ALU_result = ~val2;
            4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
                ALU_result = sum[31:0];
                is_arith   = 1'b1;
            end
            4'b0110: ALU_result = op1 & val2;
            4'b0111: ALU_result = op1 | val2;
            4'b1000: ALU_result = op1 ^ val2;
            default: cmd_valid = 1'b0;
        endcase
    end

    always_comb begin
        n_f = ALU_result[31];
        z_f = (ALU_result == 32'd0);
        c_f = SR[1];
        v_f = SR[0];
        if (is_arith) begin
            c_f = sum[32];
            v_f = (op1[31] == add_b[31]) && (sum[31] != op1[31]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SR <= 4'b0000;
        end else if (S && !Freeze && cmd_valid) begin
            SR <= {n_f, z_f, c_f, v_f};
        end
    end

    assign Branch_Address = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
    assign Branch_Taken   = B_in;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage.
// Expected values are hand-computed constants.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  EXE_CMD;
    logic        S;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        B_in;
    logic [31:0] PC;
    logic [31:0] Val_1;
    logic [31:0] Val_Rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] Signed_imm_24;
    logic        C_in;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic [31:0] MEM_ALU_result;
    logic [31:0] WB_value;
    logic        Freeze;
    logic [31:0] ALU_result;
    logic [31:0] Store_value;
    logic [31:0] Branch_Address;
    logic        Branch_Taken;
    logic [3:0]  SR;

    int passed = 0;
    int total  = 0;

    exe_stage dut (
        .clk(clk),
        .rst(rst),
        .EXE_CMD(EXE_CMD),
        .S(S),
        .MEM_R_EN(MEM_R_EN),
        .MEM_W_EN(MEM_W_EN),
        .B_in(B_in),
        .PC(PC),
        .Val_1(Val_1),
        .Val_Rm(Val_Rm),
        .imm(imm),
        .shift_operand(shift_operand),
        .Signed_imm_24(Signed_imm_24),
        .C_in(C_in),
        .sel_src1(sel_src1),
        .sel_src2(sel_src2),
        .MEM_ALU_result(MEM_ALU_result),
        .WB_value(WB_value),
        .Freeze(Freeze),
        .ALU_result(ALU_result),
        .Store_value(Store_value),
        .Branch_Address(Branch_Address),
        .Branch_Taken(Branch_Taken),
        .SR(SR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] cmd, input logic s,
                      input logic im, input logic [11:0] so,
                      input logic [31:0] v1, input logic [31:0] vrm);
        EXE_CMD       = cmd;
        S             = s;
        imm           = im;
        shift_operand = so;
        Val_1         = v1;
        Val_Rm        = vrm;
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        EXE_CMD        = 4'd0;
        S              = 1'b0;
        MEM_R_EN       = 1'b0;
        MEM_W_EN       = 1'b0;
        B_in           = 1'b0;
        PC             = 32'd0;
        Val_1          = 32'd0;
        Val_Rm         = 32'd0;
        imm            = 1'b0;
        shift_operand  = 12'd0;
        Signed_imm_24  = 24'd0;
        C_in           = 1'b0;
        sel_src1       = 2'b00;
        sel_src2       = 2'b00;
        MEM_ALU_result = 32'd0;
        WB_value       = 32'd0;
        Freeze         = 1'b0;
        #2;
        check("sr_reset", {28'd0, SR}, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // ADD overflow: 7FFFFFFF + 1
        op(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'd0);
        check("add_result", ALU_result, 32'h8000_0000);
        tick();
        check("add_flags", {28'd0, SR}, 32'h9);

        // Asynchronous reset between edges
        S = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_clear", {28'd0, SR}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("sr_after_release", {28'd0, SR}, 32'h0);

        // SUB 5-5
        op(4'b0100, 1'b1, 1'b0, 12'h000, 32'd5, 32'd5);
        check("sub_result", ALU_result, 32'h0);
        tick();
        check("sub_flags", {28'd0, SR}, 32'h6);

        // Logical op keeps C and V
        op(4'b0111, 1'b1, 1'b0, 12'h000, 32'd5, 32'd2);
        check("orr_result", ALU_result, 32'd7);
        tick();
        check("orr_flags", {28'd0, SR}, 32'h2);

        // Undefined code: result 0, SR untouched
        op(4'b1111, 1'b1, 1'b0, 12'h000, 32'd5, 32'd2);
        check("bad_cmd_result", ALU_result, 32'h0);
        tick();
        check("bad_cmd_flags", {28'd0, SR}, 32'h2);
        S = 1'b0;

        // SBC 10-3 with C_in=0, ADC 1+2 with C_in=1
        C_in = 1'b0;
        op(4'b0101, 1'b0, 1'b0, 12'h000, 32'd10, 32'd3);
        check("sbc_result", ALU_result, 32'd6);
        C_in = 1'b1;
        op(4'b0011, 1'b0, 1'b0, 12'h000, 32'd1, 32'd2);
        check("adc_result", ALU_result, 32'd4);
        op(4'b1001, 1'b0, 1'b1, 12'h000, 32'd0, 32'd0);
        check("mvn_result", ALU_result, 32'hFFFF_FFFF);
        op(4'b1000, 1'b0, 1'b1, 12'h0F0, 32'h0000_00FF, 32'd0);
        check("eor_result", ALU_result, 32'h0000_000F);
        op(4'b0110, 1'b0, 1'b1, 12'h0F0, 32'h0000_00FF, 32'd0);
        check("and_result", ALU_result, 32'h0000_00F0);

        // Register shifts on 80000001
        op(4'b0001, 1'b0, 1'b0, 12'h0C0, 32'd0, 32'h8000_0001);
        check("asr1", ALU_result, 32'hC000_0000);
        op(4'b0001, 1'b0, 1'b0, 12'h260, 32'd0, 32'h8000_0001);
        check("ror4", ALU_result, 32'h1800_0000);
        op(4'b0001, 1'b0, 1'b0, 12'h000, 32'd0, 32'h8000_0001);
        check("lsl0", ALU_result, 32'h8000_0001);
        op(4'b0001, 1'b0, 1'b0, 12'h080, 32'd0, 32'h8000_0001);
        check("lsl1", ALU_result, 32'h0000_0002);
        op(4'b0001, 1'b0, 1'b0, 12'h0A0, 32'd0, 32'h8000_0001);
        check("lsr1", ALU_result, 32'h4000_0000);

        // Rotated immediate and memory offset
        op(4'b0001, 1'b0, 1'b1, 12'h4FF, 32'd0, 32'd0);
        check("imm_rot", ALU_result, 32'hFF00_0000);
        MEM_R_EN = 1'b1;
        op(4'b0010, 1'b0, 1'b0, 12'h804, 32'h0000_0100, 32'hDEAD_BEEF);
        check("ldr_offset", ALU_result, 32'h0000_0904);
        MEM_R_EN = 1'b0;

        // Forwarding
        MEM_ALU_result = 32'd42;
        WB_value       = 32'd8;
        sel_src1       = 2'b01;
        sel_src2       = 2'b10;
        op(4'b0010, 1'b0, 1'b0, 12'h000, 32'd1000, 32'd2000);
        check("fwd_sum", ALU_result, 32'd50);
        check("fwd_store", Store_value, 32'd8);
        sel_src1 = 2'b11;
        sel_src2 = 2'b11;
        #1;
        check("sel11_sum", ALU_result, 32'd3000);
        check("sel11_store", Store_value, 32'd2000);
        sel_src1 = 2'b00;
        sel_src2 = 2'b00;

        // Freeze: SR currently 0010, pending ADD gives 1001
        Freeze = 1'b1;
        op(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_hold", {28'd0, SR}, 32'h2);
        end
        Freeze = 1'b0;
        tick();
        check("unfreeze_update", {28'd0, SR}, 32'h9);
        op(4'b0100, 1'b0, 1'b0, 12'h000, 32'd5, 32'd5);
        tick();
        check("s0_hold", {28'd0, SR}, 32'h9);

        // Branch target
        B_in          = 1'b1;
        PC            = 32'h0000_0100;
        Signed_imm_24 = 24'hFFFFFE;
        #1;
        check("br_addr_neg", Branch_Address, 32'h0000_00F8);
        check("br_taken", {31'd0, Branch_Taken}, 32'd1);
        Signed_imm_24 = 24'h000010;
        B_in          = 1'b0;
        #1;
        check("br_addr_pos", Branch_Address, 32'h0000_0140);
        check("br_not_taken", {31'd0, Branch_Taken}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
